instr_capture_unit: RTL and testbench

Instruction-fetch capture stage of the multi-cycle MIPS datapath. Issues a word read to instruction memory on request from the control FSM, waits for a variable-latency acknowledge, latches the word into the instruction register and presents decoded fields. The registered 32-bit immediate it produces feeds the ALU source-B mux. Immediate mode comes from the opcode: zero-extend for logical ops, upper-half for LUI, sign-extend otherwise.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/imm_extender.sv | 28 ++
 rtl/instr_capture_unit.sv | 134 +++++++++++++
 tb/tb_instr_capture_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multi-cycle datapath.
//   - Fetch FSM state encoding
//   - I-type opcodes whose immediate is not sign-extended
//   - Instruction field bit positions
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_W      = 16;

endpackage

// File: rtl/imm_extender.sv
// Combinational immediate extender.
//   word     in  32  instruction word
//   imm_ext  out 32  immediate extended according to the word's opcode:
//                    logical ops zero-extend, LUI moves to the upper half,
//                    everything else sign-extends.
import mips_pkg::*;

module imm_extender (
    input  logic [31:0] word,
    output logic [31:0] imm_ext
);

    logic [5:0]       op;
    logic [IMM_W-1:0] imm16;

    assign op    = word[OPCODE_LSB +: 6];
    assign imm16 = word[IMM_W-1:0];

    always_comb begin
        imm_ext = {{(32-IMM_W){imm16[IMM_W-1]}}, imm16};
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = {{(32-IMM_W){1'b0}}, imm16};
            OP_LUI:                   imm_ext = {imm16, {(32-IMM_W){1'b0}}};
            default:                  ;
        endcase
    end

endmodule

// File: rtl/instr_capture_unit.sv
// Instruction-fetch capture stage.
// Issues a read to instruction memory on fetch_req, waits (bounded by
// TIMEOUT cycles) for mem_ack, then latches the word into the IR together
// with its fetch address and registered extended immediate.
//   clk, rst_n            clock / async active-low reset
//   fetch_req, pc_in      fetch request pulse and address
//   flush                 abort outstanding fetch, invalidate IR
//   mem_rd, mem_addr      read strobe and address to instruction memory
//   mem_ack, mem_rdata    memory acknowledge and returned word
//   ir_valid, ir, ir_pc   instruction register and its fetch address
//   opcode..target        decoded field slices of ir
//   imm_ext               registered extended immediate of ir
//   busy                  fetch outstanding
//   fetch_err             sticky timeout flag
import mips_pkg::*;

module instr_capture_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [25:0] target,
    output logic [31:0] imm_ext,
    output logic        busy,
    output logic        fetch_err
);

    localparam logic [15:0] CNT_LOAD = 16'(TIMEOUT - 1);

    fetch_state_e state, state_next;
    logic [15:0]  cnt;
    logic [31:0]  imm_next;
    logic         accept;
    logic         capture;
    logic         expire;

    imm_extender u_imm_extender (
        .word    (mem_rdata),
        .imm_ext (imm_next)
    );

    // flush outranks both a same-cycle ack and a new request
    assign accept  = fetch_req && !flush && (state != ST_WAIT);
    assign capture = (state == ST_WAIT) && mem_ack && !flush;
    assign expire  = (state == ST_WAIT) && !mem_ack && !flush && (cnt == 16'd0);

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // ---- next-state logic ----
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: if (fetch_req) state_next = ST_WAIT;
                ST_WAIT: begin
                    if (mem_ack)             state_next = ST_HOLD;
                    else if (cnt == 16'd0)   state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ---- state-decoded outputs ----
    always_comb begin
        mem_rd = (state == ST_WAIT);
        busy   = (state == ST_WAIT);
    end

    // ---- fetch bookkeeping and instruction register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            cnt       <= '0;
            ir        <= '0;
            ir_pc     <= '0;
            imm_ext   <= '0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr  <= pc_in;
                cnt       <= CNT_LOAD;
                fetch_err <= 1'b0;
            end else if (state == ST_WAIT && cnt != 16'd0) begin
                // saturates at zero; only reloaded on acceptance
                cnt <= cnt - 16'd1;
            end

            if (capture) begin
                ir      <= mem_rdata;
                ir_pc   <= mem_addr;
                imm_ext <= imm_next;
            end

            if (flush || accept) ir_valid <= 1'b0;
            else if (capture)    ir_valid <= 1'b1;

            if (expire) fetch_err <= 1'b1;
        end
    end

    // ---- decoded field slices ----
    assign opcode = ir[OPCODE_LSB +: 6];
    assign rs     = ir[RS_LSB +: 5];
    assign rt     = ir[RT_LSB +: 5];
    assign rd     = ir[RD_LSB +: 5];
    assign shamt  = ir[SHAMT_LSB +: 5];
    assign funct  = ir[FUNCT_LSB +: 6];
    assign target = ir[25:0];

endmodule

// File: tb/tb_instr_capture_unit.sv
module tb_instr_capture_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] pc_in = '0;
    logic        flush = 1'b0;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ir_valid;
    logic [31:0] ir, ir_pc, imm_ext;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [25:0] target;
    logic        busy, fetch_err;

    int total = 0;
    int bad = 0;
    bit checks_on = 1'b0;

    instr_capture_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_in(pc_in),
        .flush(flush), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_valid(ir_valid),
        .ir(ir), .ir_pc(ir_pc), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .target(target), .imm_ext(imm_ext),
        .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference immediate computed arithmetically from the opcode number.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int unsigned op, imm;
        op  = w >> 26;
        imm = w & 32'hFFFF;
        if (op >= 12 && op <= 14) return imm;
        if (op == 15)             return imm * 65536;
        if (imm >= 32768)         return imm + 32'hFFFF_0000;
        return imm;
    endfunction

    // Behavioural model: an outstanding fetch, how many WAIT cycles it has
    // used, and the last captured instruction.
    bit          m_out, m_valid, m_err;
    int          m_waited;
    logic [31:0] m_addr, m_ir, m_pc, m_imm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = 0; m_valid = 0; m_err = 0; m_waited = 0;
            m_addr = 0; m_ir = 0; m_pc = 0; m_imm = 0;
        end else if (flush) begin
            m_out = 0; m_valid = 0;
        end else if (m_out) begin
            if (mem_ack) begin
                m_ir = mem_rdata; m_pc = m_addr; m_imm = ref_imm(mem_rdata);
                m_valid = 1; m_out = 0;
            end else if (m_waited + 1 == TO) begin
                m_err = 1; m_out = 0;
            end else begin
                m_waited++;
            end
        end else if (fetch_req) begin
            m_addr = pc_in; m_out = 1; m_waited = 0; m_err = 0; m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (checks_on) begin
            chk("mem_rd",    32'(mem_rd),    32'(m_out));
            chk("busy",      32'(busy),      32'(m_out));
            chk("mem_addr",  mem_addr,       m_addr);
            chk("ir_valid",  32'(ir_valid),  32'(m_valid));
            chk("ir",        ir,             m_ir);
            chk("ir_pc",     ir_pc,          m_pc);
            chk("imm_ext",   imm_ext,        m_imm);
            chk("fetch_err", 32'(fetch_err), 32'(m_err));
            chk("opcode",    32'(opcode),    m_ir >> 26);
            chk("rs",        32'(rs),        (m_ir >> 21) & 31);
            chk("rt",        32'(rt),        (m_ir >> 16) & 31);
            chk("rd",        32'(rd),        (m_ir >> 11) & 31);
            chk("shamt",     32'(shamt),     (m_ir >> 6) & 31);
            chk("funct",     32'(funct),     m_ir & 63);
            chk("target",    32'(target),    m_ir & 32'h03FF_FFFF);
        end
    end

    task automatic request(input logic [31:0] pc);
        @(negedge clk); fetch_req = 1'b1; pc_in = pc;
        @(negedge clk); fetch_req = 1'b0;
    endtask

    // ack arrives in WAIT cycle number delay+1
    task automatic fetch(input logic [31:0] pc, input int delay, input logic [31:0] word);
        request(pc);
        repeat (delay) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = word;
        @(negedge clk); mem_ack = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_rd",   32'(mem_rd), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_ir_valid", 32'(ir_valid), 0);
        chk("rst_ir",       ir, 0);
        chk("rst_imm",      imm_ext, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_err",      32'(fetch_err), 0);
        rst_n = 1'b1;
        checks_on = 1'b1;

        // LUI, ack in third WAIT cycle
        fetch(32'h0040_0000, 2, 32'h3C01_1234);
        chk("lui_imm",   imm_ext, 32'h1234_0000);
        chk("lui_pc",    ir_pc, 32'h0040_0000);
        chk("lui_valid", 32'(ir_valid), 1);

        // ORI with minimum latency: valid two cycles after the request edge
        request(32'h0000_1000);
        chk("ori_not_yet", 32'(ir_valid), 0);
        mem_ack = 1'b1; mem_rdata = 32'h3421_8001;
        @(negedge clk); mem_ack = 1'b0;
        chk("ori_valid", 32'(ir_valid), 1);
        chk("ori_imm",   imm_ext, 32'h0000_8001);

        // ADDI sign-extends
        fetch(32'h0000_1004, 0, 32'h2021_8001);
        chk("addi_imm", imm_ext, 32'hFFFF_8001);

        // timeout, then a late ack that must be ignored
        request(32'h0000_2000);
        repeat (TO) @(negedge clk);
        chk("to_err",    32'(fetch_err), 1);
        chk("to_mem_rd", 32'(mem_rd), 0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); mem_ack = 1'b0;
        chk("late_ack_ir", ir, 32'h2021_8001);

        // next accepted request clears the error; ANDI zero-extends
        fetch(32'h0000_2004, 1, 32'h3021_F0F0);
        chk("err_clear", 32'(fetch_err), 0);
        chk("andi_imm",  imm_ext, 32'h0000_F0F0);

        // ack in the last WAIT cycle (counter at zero) wins over timeout
        fetch(32'h0000_2008, TO - 1, 32'h3821_8000);
        chk("last_ack_err", 32'(fetch_err), 0);
        chk("xori_imm",     imm_ext, 32'h0000_8000);

        // flush and ack together
        request(32'h0000_3000);
        flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk); flush = 1'b0; mem_ack = 1'b0;
        chk("flush_valid", 32'(ir_valid), 0);
        chk("flush_ir",    ir, 32'h3821_8000);
        chk("flush_busy",  32'(busy), 0);

        // HOLD + new request; extra requests during WAIT are ignored
        fetch(32'h0000_4000, 0, 32'h8C22_0004);
        request(32'h0000_4004);
        fetch_req = 1'b1; pc_in = 32'h0000_9999;
        @(negedge clk); fetch_req = 1'b0;
        chk("wait_addr",  mem_addr, 32'h0000_4004);
        chk("hold_ir",    ir, 32'h8C22_0004);
        mem_ack = 1'b1; mem_rdata = 32'h2002_FFFF;
        @(negedge clk); mem_ack = 1'b0;
        chk("new_ir",  ir, 32'h2002_FFFF);
        chk("new_imm", imm_ext, 32'hFFFF_FFFF);
        chk("new_pc",  ir_pc, 32'h0000_4004);
        repeat (2) @(negedge clk);
        chk("one_capture_busy", 32'(busy), 0);

        // asynchronous reset in WAIT
        request(32'h0000_5000);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_rd",   32'(mem_rd), 0);
        chk("arst_busy",     32'(busy), 0);
        chk("arst_ir_valid", 32'(ir_valid), 0);
        chk("arst_ir",       ir, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
